// File: rtl/ty_ctrl_pkg.sv
// ty_ctrl_pkg: shared FSM state encoding and default sequencing parameters
package ty_ctrl_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DRAIN, ST_DONE} state_e;
  localparam int unsigned PIPE_LAT_DEF = 6;
  localparam int unsigned BEAT_SHIFT_DEF = 2;
endpackage

// File: rtl/ty_beat_counter.sv
// ty_beat_counter: saturating beat counter with clear, enable and terminal detect
module ty_beat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge aclk) cnt_q <= areset ? '0 : cnt_d;
  assign cnt = cnt_q;
  // high on the increment that lands exactly on term
  assign last = en && ({1'b0, cnt_q} + (W+1)'(1) == {1'b0, term});
endmodule

// File: rtl/ty_stream_seq.sv
// ty_stream_seq: sequences one streaming transfer through a fixed-latency kernel,
// then pushes flush bubbles so the tail of the transfer drains out.
module ty_stream_seq
  import ty_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = PIPE_LAT_DEF,
  parameter int unsigned BEAT_SHIFT = BEAT_SHIFT_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic [CNT_W-1:0] xfer_bytes,
  output logic             busy,
  output logic             done,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             k_ivalid,
  input  logic             k_iready,
  input  logic             k_ovalid,
  output logic             k_oready,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] beats_q, beats_d, flush_cnt;
  logic clr, run, flush, active, out_below;
  logic in_en, flush_en, out_en, in_last, flush_last, out_last, flush_fin;

  assign run       = state_q == ST_RUN;
  assign flush     = state_q == ST_FLUSH;
  assign active    = run || flush || state_q == ST_DRAIN;
  assign out_below = out_cnt < beats_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
  assign s_tready  = run && k_iready;
  assign k_ivalid  = (run && s_tvalid) || flush;
  assign m_tvalid  = active && k_ovalid && out_below;
  // once every real beat is out, anything else the kernel emits is a bubble and is dropped
  assign k_oready  = active && (out_below ? m_tready : 1'b1);
  assign in_en     = run && s_tvalid && k_iready;
  assign flush_en  = flush && k_iready;
  assign out_en    = m_tvalid && m_tready;
  assign flush_fin = flush_last || flush_cnt >= CNT_W'(PIPE_LAT);

  ty_beat_counter #(.W(CNT_W)) u_in_cnt (
    .aclk(aclk), .areset(areset), .clr(clr), .en(in_en),
    .term(beats_q), .cnt(in_cnt), .last(in_last)
  );
  ty_beat_counter #(.W(CNT_W)) u_out_cnt (
    .aclk(aclk), .areset(areset), .clr(clr), .en(out_en),
    .term(beats_q), .cnt(out_cnt), .last(out_last)
  );
  ty_beat_counter #(.W(CNT_W)) u_flush_cnt (
    .aclk(aclk), .areset(areset), .clr(clr), .en(flush_en),
    .term(CNT_W'(PIPE_LAT)), .cnt(flush_cnt), .last(flush_last)
  );

  // completion of the output side overrides any other progress
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        clr     = 1'b1;
        beats_d = xfer_bytes >> BEAT_SHIFT;
        state_d = (beats_d == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   state_d = out_last ? ST_DONE : in_last ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = out_last ? ST_DONE : flush_fin ? ST_DRAIN : ST_FLUSH;
      ST_DRAIN: state_d = out_last ? ST_DONE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end
endmodule

// File: tb/tb_ty_stream_seq.sv
// tb_ty_stream_seq: random and directed transfers against a latency-model kernel,
// with a tag scoreboard checked by an independent monitor.
module tb_ty_stream_seq;
  localparam int PL = 6;

  logic aclk = 0, areset = 1, start = 0;
  logic [31:0] xfer_bytes = 0;
  logic busy, done, s_tready, k_ivalid, k_oready, m_tvalid;
  logic s_tvalid = 1, k_iready = 1, k_ovalid = 0, m_tready = 1;
  logic [31:0] in_cnt, out_cnt;

  always #5 aclk = ~aclk;

  ty_stream_seq #(.PIPE_LAT(PL), .BEAT_SHIFT(2), .CNT_W(32)) dut (
    .aclk(aclk), .areset(areset), .start(start), .xfer_bytes(xfer_bytes),
    .busy(busy), .done(done), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .k_ivalid(k_ivalid), .k_iready(k_iready), .k_ovalid(k_ovalid), .k_oready(k_oready),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  typedef struct {int tag; int age;} kitem_t;
  kitem_t kq[$];
  int exp_q[$];
  int errors = 0, checks = 0;
  int exp_beats = 0, xfer_id = 0, done_id = 0, bub_cnt = 0, tag_n = 0;
  int ncyc = 0, last_m = 0, m_x = 0;
  bit aborted = 0, prev_done = 0, rst_edge = 1;
  bit s_rand = 0, k_rand = 0, stall_req = 0, stall_used = 0;
  int m_mode = 0, stall_left = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // input driver: upstream valid, kernel input ready, downstream ready
  always @(posedge aclk) begin
    #1;
    s_tvalid = s_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_tready = (m_mode == 2) ? ~m_tready : (m_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!stall_req) stall_used = 0;
    else if (!stall_used && busy && !done && int'(in_cnt) == exp_beats) begin
      stall_left = 3;
      stall_used = 1;
    end
    k_iready = (stall_left > 0) ? 1'b0 : k_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_left > 0) stall_left--;
  end

  // kernel model: items age only while the kernel advances (k_iready), emerge after PL ticks
  always begin
    bit kin, kout, sin, adv, rst, dn;
    @(negedge aclk);
    kin = k_ivalid && k_iready;
    kout = k_ovalid && k_oready;
    sin = s_tvalid && s_tready;
    adv = k_iready;
    rst = areset;
    dn = done;
    if (rst) exp_q.delete();
    else begin
      if (start && !busy) bub_cnt = 0;
      if (sin) exp_q.push_back(tag_n);
      if (kin && !sin) bub_cnt++;
    end
    @(posedge aclk);
    #1;
    if (rst || dn) kq.delete();
    else begin
      if (kout) void'(kq.pop_front());
      if (adv) foreach (kq[i]) kq[i].age++;
      if (kin) kq.push_back('{tag: sin ? tag_n : -1, age: 0});
    end
    if (sin) tag_n++;
    k_ovalid = kq.size() != 0 && kq[0].age >= PL;
  end

  always @(posedge aclk) rst_edge <= areset;

  // monitor: every comparison of the run happens here
  always begin
    int head, e;
    @(negedge aclk);
    ncyc++;
    if (rst_edge)
      chk(!busy && !done && in_cnt == 0 && out_cnt == 0, "reset_state",
          {busy, done, in_cnt != 0, out_cnt != 0}, 0);
    if (areset) begin
      m_x = 0;
      prev_done = 0;
    end else begin
      if (!busy || done)
        chk(!(s_tready || k_ivalid || m_tvalid || k_oready), "idle_quiet",
            {s_tready, k_ivalid, m_tvalid, k_oready}, 0);
      if (start && !busy) m_x = 0;
      head = (kq.size() != 0) ? kq[0].tag : -2;
      if (m_tvalid) chk(head >= 0, "bubble_visible", head, 0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk(1'b0, "extra_out", head, -1);
        else begin
          e = exp_q.pop_front();
          chk(head == e, "out_order", head, e);
        end
        m_x++;
        last_m = ncyc;
      end
      if (prev_done) chk(!done && !busy, "done_pulse", {done, busy}, 0);
      if (done) begin
        chk(!aborted && xfer_id != done_id, "done_expected", done_id, xfer_id);
        done_id = xfer_id;
        chk(int'(in_cnt) == exp_beats, "in_cnt", in_cnt, exp_beats);
        chk(int'(out_cnt) == exp_beats, "out_cnt", out_cnt, exp_beats);
        chk(m_x == exp_beats, "m_beats", m_x, exp_beats);
        chk(bub_cnt == (exp_beats > 0 ? PL : 0), "bubbles", bub_cnt, exp_beats > 0 ? PL : 0);
        chk(exp_q.size() == 0, "pending_out", exp_q.size(), 0);
        if (exp_beats > 0) chk(last_m == ncyc - 1, "done_latency", ncyc - last_m, 1);
      end
      prev_done = done;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (!done) begin
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      $fatal(1);
    end
  endtask

  task automatic xfer(input int bytes, input bit mid);
    exp_beats = bytes >> 2;
    xfer_id++;
    aborted = 0;
    @(posedge aclk); #1;
    start = 1;
    xfer_bytes = bytes;
    @(posedge aclk); #1;
    start = 0;
    if (mid) begin
      repeat (3) @(posedge aclk);
      #1;
      start = 1;
      xfer_bytes = 8;
      @(posedge aclk); #1;
      start = 0;
    end
    wait_done();
    @(negedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1 areset = 0;
    xfer(64, 0);
    xfer(0, 0);
    m_mode = 2;
    xfer(32, 0);
    m_mode = 0;
    stall_req = 1;
    xfer(64, 0);
    stall_req = 0;
    xfer(64, 1);
    // abort mid-transfer, then a clean short transfer
    exp_beats = 16;
    xfer_id++;
    @(posedge aclk); #1;
    start = 1;
    xfer_bytes = 64;
    @(posedge aclk); #1;
    start = 0;
    for (int n = 0; n < 200 && in_cnt != 5; n++) begin
      @(negedge aclk);
      #1;
    end
    if (in_cnt != 5) begin
      $display("FAIL abort_wait: got in_cnt=%0d expected 5", in_cnt);
      $fatal(1);
    end
    aborted = 1;
    @(posedge aclk); #1;
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    repeat (4) @(posedge aclk);
    xfer(16, 0);
    s_rand = 1;
    k_rand = 1;
    m_mode = 1;
    for (int i = 0; i < 20; i++) xfer(int'($urandom_range(0, 160)), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
